// File: rtl/crc_mem_pkg.sv
// Shared constants and types for the CRC-protected memory sequencer.
// Memory words are DATA_W data bits plus CRC_W check bits.
package crc_mem_pkg;
    localparam int ADDR_W_DEF       = 4;
    localparam int SHIFT_CYCLES_DEF = 8;
    localparam int DATA_W           = 8;
    localparam int CRC_W            = 4;
    localparam int WORD_W           = DATA_W + CRC_W;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ENC_LOAD  = 3'd1;
    localparam state_t ST_ENC_SHIFT = 3'd2;
    localparam state_t ST_MEM_WRITE = 3'd3;
    localparam state_t ST_DEC_LOAD  = 3'd4;
    localparam state_t ST_DEC_SHIFT = 3'd5;
    localparam state_t ST_DONE      = 3'd6;

    typedef enum logic {
        SRC_HOST  = 1'b0,
        SRC_SCRUB = 1'b1
    } src_e;
endpackage

// File: rtl/crc_mem_access_sequencer_if.sv
// Host request/response bus of the CRC memory sequencer.
interface crc_mem_access_sequencer_if #(
    parameter int ADDR_W = 4
);
    logic              host_write;
    logic              host_read;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ready;
    logic              host_rvalid;
    logic              host_rerror;

    modport master (
        output host_write, host_read, host_addr,
        input  host_ready, host_rvalid, host_rerror
    );

    modport slave (
        input  host_write, host_read, host_addr,
        output host_ready, host_rvalid, host_rerror
    );
endinterface

// File: rtl/crc_scrub_scheduler.sv
// Background scrub timing: idle-cycle interval counter and the next address to scrub.
module crc_scrub_scheduler #(
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              idle,
    input  logic              scrub_en,
    input  logic              scrub_accept,
    input  logic              scrub_done,
    output logic              scrub_due,
    output logic [ADDR_W-1:0] scrub_ptr
);
    localparam int IC_W = $clog2(SCRUB_INTERVAL);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(SCRUB_INTERVAL - 1);

    logic [IC_W-1:0] interval_cnt;

    assign scrub_due = scrub_en && (interval_cnt == IC_LAST);

    // A due scrub parks at terminal count until it is actually accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            interval_cnt <= '0;
            scrub_ptr    <= '0;
        end else begin
            if (!scrub_en || scrub_accept) begin
                interval_cnt <= '0;
            end else if (idle && !scrub_due) begin
                interval_cnt <= interval_cnt + 1'b1;
            end
            if (scrub_done) begin
                scrub_ptr <= scrub_ptr + 1'b1;
            end
        end
    end
endmodule

// File: rtl/crc_mem_access_sequencer.sv
// Sequences encoder, memory write port and decoder for one CRC-protected memory,
// arbitrating host writes, host reads and background scrub reads.
//
// state        | meaning
// IDLE         | ready for a request; arbitration write > read > scrub
// ENC_LOAD     | parallel load of the encoder
// ENC_SHIFT    | SHIFT_CYCLES encoder shift cycles
// MEM_WRITE    | single memory write strobe
// DEC_LOAD     | parallel load of the decoder
// DEC_SHIFT    | SHIFT_CYCLES decoder shift cycles
// DONE         | decoder result sampled, reported to host or scrub
module crc_mem_access_sequencer
    import crc_mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int SHIFT_CYCLES   = SHIFT_CYCLES_DEF,
    parameter int SCRUB_INTERVAL = 64,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    crc_mem_access_sequencer_if.slave host,
    input  logic                   scrub_en,
    input  logic                   dec_error,
    output logic                   enc_load,
    output logic                   enc_shift,
    output logic                   mem_wr_en,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   dec_load,
    output logic                   dec_shift,
    output logic                   scrub_err_valid,
    output logic [ADDR_W-1:0]      scrub_err_addr,
    output logic [CNT_W-1:0]       err_count
);
    localparam int SC_W = $clog2(SHIFT_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SHIFT_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    src_e              src;
    logic [SC_W-1:0]   shift_cnt;
    logic              idle;
    logic              accept_wr;
    logic              accept_rd;
    logic              accept_scrub;
    logic              shift_last;
    logic              in_shift;
    logic              done_host;
    logic              done_scrub;
    logic              scrub_due;
    logic [ADDR_W-1:0] scrub_ptr;

    assign idle         = (state == ST_IDLE);
    assign accept_wr    = idle && host.host_write;
    assign accept_rd    = idle && !host.host_write && host.host_read;
    assign accept_scrub = idle && !host.host_write && !host.host_read && scrub_due;
    assign shift_last   = (shift_cnt == SC_LAST);
    assign in_shift     = (state == ST_ENC_SHIFT) || (state == ST_DEC_SHIFT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept_wr) begin
                    state_nxt = ST_ENC_LOAD;
                end else if (accept_rd || accept_scrub) begin
                    state_nxt = ST_DEC_LOAD;
                end
            end
            ST_ENC_LOAD:  state_nxt = ST_ENC_SHIFT;
            ST_ENC_SHIFT: if (shift_last) state_nxt = ST_MEM_WRITE;
            ST_MEM_WRITE: state_nxt = ST_IDLE;
            ST_DEC_LOAD:  state_nxt = ST_DEC_SHIFT;
            ST_DEC_SHIFT: if (shift_last) state_nxt = ST_DONE;
            ST_DONE:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so no output can glitch on decode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= ST_IDLE;
            src             <= SRC_HOST;
            shift_cnt       <= '0;
            mem_addr        <= '0;
            host.host_ready <= 1'b1;
            enc_load        <= 1'b0;
            enc_shift       <= 1'b0;
            mem_wr_en       <= 1'b0;
            dec_load        <= 1'b0;
            dec_shift       <= 1'b0;
            done_host       <= 1'b0;
            done_scrub      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_shift && (state_nxt == state)) begin
                shift_cnt <= shift_cnt + 1'b1;
            end else begin
                shift_cnt <= '0;
            end
            if (accept_wr || accept_rd) begin
                mem_addr <= host.host_addr;
                src      <= SRC_HOST;
            end else if (accept_scrub) begin
                mem_addr <= scrub_ptr;
                src      <= SRC_SCRUB;
            end
            host.host_ready <= (state_nxt == ST_IDLE);
            enc_load        <= (state_nxt == ST_ENC_LOAD);
            enc_shift       <= (state_nxt == ST_ENC_SHIFT);
            mem_wr_en       <= (state_nxt == ST_MEM_WRITE);
            dec_load        <= (state_nxt == ST_DEC_LOAD);
            dec_shift       <= (state_nxt == ST_DEC_SHIFT);
            done_host       <= (state_nxt == ST_DONE) && (src == SRC_HOST);
            done_scrub      <= (state_nxt == ST_DONE) && (src == SRC_SCRUB);
        end
    end

    assign host.host_rvalid = done_host;
    assign host.host_rerror = done_host && dec_error;
    assign scrub_err_valid  = done_scrub && dec_error;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_count      <= '0;
            scrub_err_addr <= '0;
        end else begin
            if ((done_host || done_scrub) && dec_error && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
            if (scrub_err_valid) begin
                scrub_err_addr <= mem_addr;
            end
        end
    end

    crc_scrub_scheduler #(
        .ADDR_W         (ADDR_W),
        .SCRUB_INTERVAL (SCRUB_INTERVAL)
    ) u_scrub (
        .clk          (clk),
        .rst          (rst),
        .idle         (idle),
        .scrub_en     (scrub_en),
        .scrub_accept (accept_scrub),
        .scrub_done   (done_scrub),
        .scrub_due    (scrub_due),
        .scrub_ptr    (scrub_ptr)
    );
endmodule

// File: doc/crc_mem_access_sequencer.md
Name: crc_mem_access_sequencer

Overview:
- Sequences one CRC-protected 16x8 memory: the bit-serial CRC encoder, the write port and the bit-serial CRC decoder.
- Arbitrates the memory between host writes, host reads and a background scrubber. The scrubber periodically re-reads every word and reports CRC failures.
- Sits between the host interface and the encoder/memory/decoder datapath. Replaces the write-only controller, and adds the decoder sequencing and error bookkeeping that the datapath currently lacks.

Parameters:
- ADDR_W, 4, memory address width (depth = 2**ADDR_W).
- SHIFT_CYCLES, 8, serial shift cycles per encode/decode (one per data bit).
- SCRUB_INTERVAL, 64, idle cycles between scrub reads (>= 2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- host_write  in  1  write request; sampled only while host_ready=1.
- host_read  in  1  read request; sampled only while host_ready=1.
- host_addr  in  ADDR_W  request address; sampled at accept.
- scrub_en  in  1  enables background scrubbing.
- dec_error  in  1  decoder CRC-mismatch flag; valid in DONE.
- host_ready  out  1  high in IDLE only.
- host_rvalid  out  1  1-cycle pulse: host read result valid.
- host_rerror  out  1  qualifies host_rvalid; CRC error on host read.
- enc_load  out  1  encoder parallel load.
- enc_shift  out  1  encoder shift enable.
- mem_wr_en  out  1  memory write strobe.
- mem_addr  out  ADDR_W  latched operation address (write and read port).
- dec_load  out  1  decoder parallel load.
- dec_shift  out  1  decoder shift enable.
- scrub_err_valid  out  1  1-cycle pulse: scrub read failed CRC.
- scrub_err_addr  out  ADDR_W  address of last failing scrub read (held).
- err_count  out  CNT_W  saturating count of all CRC failures.

Behaviour:
- Reset (rst=0, async): FSM=IDLE, host_ready=1, all other outputs 0, scrub pointer=0, interval counter=0.
- FSM states: IDLE, ENC_LOAD, ENC_SHIFT, MEM_WRITE, DEC_LOAD, DEC_SHIFT, DONE.
- Arbitration in IDLE (fixed priority): host_write > host_read > scrub_due.
  - Both host_write and host_read high: the write is taken; the read is not latched, so the host must re-assert it.
  - Accept latches host_addr (or the scrub pointer) into mem_addr, plus a source flag (host/scrub).
- Write path: IDLE(accept) -> ENC_LOAD (enc_load=1, 1 cycle) -> ENC_SHIFT (enc_shift=1, SHIFT_CYCLES cycles) -> MEM_WRITE (mem_wr_en=1, 1 cycle) -> IDLE.
  - host_ready returns SHIFT_CYCLES+2 cycles after the accept edge (10 at default).
- Read path: IDLE(accept) -> DEC_LOAD (dec_load=1) -> DEC_SHIFT (dec_shift=1, SHIFT_CYCLES cycles) -> DONE (1 cycle) -> IDLE.
  - In DONE, dec_error is sampled.
  - Host source: host_rvalid=1 and host_rerror=dec_error for exactly that cycle.
  - Scrub source: scrub_err_valid=dec_error and scrub_err_addr<=mem_addr on error; then the scrub pointer increments, wrapping 2**ADDR_W-1 -> 0.
- err_count increments on every DONE with dec_error=1, regardless of source; it saturates at all-ones.
- Shift counter: ceil(log2(SHIFT_CYCLES+1)) bits. Cleared on entering a *_SHIFT state; the state exits when count = SHIFT_CYCLES-1.
- Scrub interval counter:
  - Counts only while in IDLE with scrub_en=1; holds otherwise.
  - scrub_due=1 when count = SCRUB_INTERVAL-1.
  - Clears to 0 when a scrub is accepted and when scrub_en=0.
  - A due scrub blocked by a host request stays due (does not restart).
- mem_addr is stable for the whole operation and is never updated outside an accept.
- Host requests arriving while host_ready=0 are ignored (no queueing).
- Reset mid-operation aborts immediately. No partial mem_wr_en may be issued and no outputs glitch high on release.
- At most one of enc_load, enc_shift, mem_wr_en, dec_load, dec_shift is high in any cycle.

Decomposition:
- Shared package crc_mem_pkg holds:
  - the state enum,
  - ADDR_W / SHIFT_CYCLES defaults,
  - the CRC width constant (4) used by the encoder/decoder/memory word (12 bits).
- One natural sub-module: crc_scrub_scheduler. It owns the interval counter, the scrub pointer and scrub_due, with inputs idle, scrub_en, scrub_accept, scrub_done.

Test Plan:
- Reset then host_write=1, addr=4'h3 for one cycle:
  - enc_load at cycle 1, enc_shift cycles 2-9, mem_wr_en with mem_addr=3 at cycle 10;
  - host_ready=1 at cycle 11.
- Host_read addr=4'h3 with dec_error=0:
  - dec_load then 8 dec_shift;
  - host_rvalid=1, host_rerror=0 on cycle 10;
  - err_count stays 0.
- host_write and host_read both high in IDLE -> write sequence only; no host_rvalid.
- scrub_en=1, no host traffic, dec_error forced 1 on address 5 only:
  - scrub reads addresses 0,1,2,... every 64+10 cycles;
  - single scrub_err_valid with scrub_err_addr=5;
  - err_count=1; pointer wraps 15->0.
- Scrub due while a host write is in progress:
  - the scrub starts on the first IDLE cycle with no host request;
  - a host_read asserted in that same cycle wins; the scrub follows it.
- Force dec_error=1 for 300 reads -> err_count saturates at 255.
- Assert rst mid-ENC_SHIFT -> all outputs 0 asynchronously; no mem_wr_en after release.
